// File: rtl/nand_logic_pkg.sv
// Shared opcode and state definitions for the NAND logic unit scheduler.
// Pure declarations; no timing or flow control of its own.
package nand_logic_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOTA = 3'd0;
    localparam opcode_t OP_NOTB = 3'd1;
    localparam opcode_t OP_NAND = 3'd2;
    localparam opcode_t OP_AND  = 3'd3;
    localparam opcode_t OP_OR   = 3'd4;
    localparam opcode_t OP_NOR  = 3'd5;
    localparam opcode_t OP_XOR  = 3'd6;
    localparam opcode_t OP_XNOR = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nand_gate_bank_bit.sv
// One-bit logic cell: all eight opcodes built from 2-input NANDs, selected by op.
// Combinational, zero latency; no flow control.
module nand_gate_bank_bit
    import nand_logic_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);

    logic w_n_ab, w_n_a, w_n_b, w_and, w_or, w_nor;
    logic w_x_a, w_x_b, w_xor, w_xnor;

    nand u_n_ab (w_n_ab, a, b);
    nand u_n_a  (w_n_a, a, a);
    nand u_n_b  (w_n_b, b, b);
    nand u_and  (w_and, w_n_ab, w_n_ab);
    nand u_or   (w_or, w_n_a, w_n_b);
    nand u_nor  (w_nor, w_or, w_or);
    // Classic four-NAND XOR sharing the a/b NAND term.
    nand u_x_a  (w_x_a, a, w_n_ab);
    nand u_x_b  (w_x_b, b, w_n_ab);
    nand u_xor  (w_xor, w_x_a, w_x_b);
    nand u_xnor (w_xnor, w_xor, w_xor);

    always_comb begin
        y = 1'b0;
        case (opcode_t'(op))
            OP_NOTA: y = w_n_a;
            OP_NOTB: y = w_n_b;
            OP_NAND: y = w_n_ab;
            OP_AND:  y = w_and;
            OP_OR:   y = w_or;
            OP_NOR:  y = w_nor;
            OP_XOR:  y = w_xor;
            OP_XNOR: y = w_xnor;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/nand_logic_unit_scheduler.sv
// Round-robin share of one bit-serial NAND cell among NREQ requesters; gnt 1 cycle after req, done WIDTH cycles after gnt.
// No queuing: requests seen while busy wait for the next IDLE edge; requesters hold req until gnt.
module nand_logic_unit_scheduler
    import nand_logic_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ),
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     op_in,
    input  logic [WIDTH*NREQ-1:0] a_in,
    input  logic [WIDTH*NREQ-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result
);

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr, r_id, r_done_id, w_win;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_shift, r_result, w_shift_nxt;
    logic [WIDTH:0]   w_cat;
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic             r_done, w_any, w_last, w_y;

    nand_gate_bank_bit u_bank (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .op (r_op),
        .y  (w_y)
    );

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_any && req[(int'(r_rr_ptr) + i) % NREQ]) begin
                w_any = 1'b1;
                w_win = IDW'((int'(r_rr_ptr) + i) % NREQ);
            end
        end
    end

    assign w_last      = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_cat       = {w_y, r_shift};
    assign w_shift_nxt = w_cat[WIDTH:1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_id      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_result  <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_gnt[w_win] <= 1'b1;
                    r_rr_ptr     <= w_win;
                    r_id         <= w_win;
                    r_op         <= op_in[3*w_win +: 3];
                    r_a          <= a_in[WIDTH*w_win +: WIDTH];
                    r_b          <= b_in[WIDTH*w_win +: WIDTH];
                    r_cnt        <= '0;
                end
            end else begin
                // Operands shift right so the cell always sees the current bit at [0].
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result  <= w_shift_nxt;
                    r_done_id <= r_id;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state == RUN);
    assign done    = r_done;
    assign done_id = r_done_id;
    assign result  = r_result;

endmodule

// File: tb/tb_nand_logic_unit_scheduler.sv
// Directed bench: table-driven opcode sweep plus hand-written arbitration, reset and WIDTH=1 sequences.
module tb_nand_logic_unit_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] op_in;
    logic [31:0] a_in, b_in;
    logic [3:0]  gnt;
    logic        busy, done;
    logic [1:0]  done_id;
    logic [7:0]  result;

    logic [1:0]  s_req;
    logic [5:0]  s_op;
    logic [1:0]  s_a, s_b;
    logic [1:0]  s_gnt;
    logic        s_busy, s_done;
    logic        s_done_id;
    logic        s_result;

    int checks = 0;
    int errors = 0;
    int cyc_now = 0;

    always #5 clk = ~clk;

    nand_logic_unit_scheduler #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    nand_logic_unit_scheduler #(.NREQ(2), .WIDTH(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .req(s_req), .op_in(s_op), .a_in(s_a), .b_in(s_b),
        .gnt(s_gnt), .busy(s_busy), .done(s_done), .done_id(s_done_id), .result(s_result)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        op_in[3*i +: 3] = op;
        a_in[8*i +: 8]  = a;
        b_in[8*i +: 8]  = b;
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt == 4'b0 && cyc < 40);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 40);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int t0;
        bit saw_gnt;
        bit saw_done;

        vecs[0] = '{3'd0, 8'hCA, 8'h0F, 8'h35};
        vecs[1] = '{3'd1, 8'hCA, 8'h0F, 8'hF0};
        vecs[2] = '{3'd2, 8'hCA, 8'h0F, 8'hF5};
        vecs[3] = '{3'd3, 8'hCA, 8'h0F, 8'h0A};
        vecs[4] = '{3'd4, 8'hCA, 8'h0F, 8'hCF};
        vecs[5] = '{3'd5, 8'hCA, 8'h0F, 8'h30};
        vecs[6] = '{3'd6, 8'hCA, 8'h0F, 8'hC5};
        vecs[7] = '{3'd7, 8'hCA, 8'h0F, 8'h3A};

        rst_n = 1'b0;
        req = '0; op_in = '0; a_in = '0; b_in = '0;
        s_req = '0; s_op = '0; s_a = '0; s_b = '0;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_done_id", 32'(done_id), 32'h0);
        chk("reset_result", 32'(result), 32'h0);
        rst_n = 1'b1;

        // Opcode sweep on requester 0.
        for (int v = 0; v < 8; v++) begin
            set_slot(0, vecs[v].op, vecs[v].a, vecs[v].b);
            req[0] = 1'b1;
            tick();
            chk($sformatf("sweep%0d_gnt", v), 32'(gnt), 32'h1);
            req[0] = 1'b0;
            wait_done(n);
            chk($sformatf("sweep%0d_latency", v), n, 8);
            chk($sformatf("sweep%0d_result", v), 32'(result), 32'(vecs[v].exp));
            chk($sformatf("sweep%0d_done_id", v), 32'(done_id), 32'h0);
        end

        // Round-robin with all four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 3'd3, 8'hFF, 8'(i + 1));
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(n);
            chk($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(4'b0001 << i));
            if (i > 0) chk($sformatf("rr%0d_spacing", i), n, 9);
            req[i] = 1'b0;
        end
        req = 4'b1001;
        wait_gnt(n);
        chk("rr_rearm_gnt", 32'(gnt), 32'h1);
        chk("rr_rearm_spacing", n, 9);
        req[0] = 1'b0;
        wait_gnt(n);
        chk("rr_rearm_gnt3", 32'(gnt), 32'h8);
        req = '0;
        wait_done(n);
        chk("rr_last_done_id", 32'(done_id), 32'h3);
        chk("rr_last_result", 32'(result), 32'h04);

        // Late request during requester 1's operation.
        set_slot(1, 3'd4, 8'h00, 8'h00);
        set_slot(2, 3'd3, 8'hFF, 8'h55);
        req = 4'b0010;
        tick();
        chk("late_gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();
        tick();
        req[2] = 1'b1;
        saw_gnt = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (gnt != 4'b0) saw_gnt = 1'b1;
            tick();
            n++;
        end
        chk("late_no_gnt_in_run", 32'(saw_gnt), 32'h0);
        chk("late_done_id1", 32'(done_id), 32'h1);
        tick();
        chk("late_gnt2", 32'(gnt), 32'h4);
        req = '0;
        wait_done(n);
        chk("late_done_id2", 32'(done_id), 32'h2);
        chk("late_result", 32'(result), 32'h55);

        // Operand changes after grant must not matter.
        set_slot(0, 3'd4, 8'hCA, 8'h0F);
        req = 4'b0001;
        tick();
        chk("opchg_gnt", 32'(gnt), 32'h1);
        req = '0;
        a_in[7:0] = 8'h00;
        wait_done(n);
        chk("opchg_result", 32'(result), 32'hCF);

        // Reset in the middle of an operation.
        set_slot(0, 3'd1, 8'h00, 8'h00);
        req = 4'b0001;
        tick();
        chk("rstmid_gnt", 32'(gnt), 32'h1);
        req = '0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_done", 32'(done), 32'h0);
        chk("rstmid_result", 32'(result), 32'h0);
        chk("rstmid_done_id", 32'(done_id), 32'h0);
        chk("rstmid_gnt_clr", 32'(gnt), 32'h0);
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("rstmid_no_done", 32'(saw_done), 32'h0);
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("rstmid_first_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_done(n);
        chk("rstmid_after_latency", n, 8);

        // WIDTH=1, NREQ=2 instance: XOR on both requesters back to back.
        s_op = {3'd6, 3'd6};
        s_a  = 2'b11;
        s_b  = 2'b01;
        s_req = 2'b11;
        tick();
        chk("w1_gnt0", 32'(s_gnt), 32'h1);
        t0 = cyc_now;
        s_req[0] = 1'b0;
        tick();
        chk("w1_done0", 32'(s_done), 32'h1);
        chk("w1_result0", 32'(s_result), 32'h0);
        chk("w1_done_id0", 32'(s_done_id), 32'h0);
        chk("w1_no_gnt_with_done", 32'(s_gnt), 32'h0);
        tick();
        chk("w1_gnt1", 32'(s_gnt), 32'h2);
        chk("w1_spacing", cyc_now - t0, 2);
        s_req = '0;
        tick();
        chk("w1_done1", 32'(s_done), 32'h1);
        chk("w1_result1", 32'(s_result), 32'h1);
        chk("w1_done_id1", 32'(s_done_id), 32'h1);
        tick();
        chk("w1_done_pulse", 32'(s_done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
